// File: rtl/spio_pkt_arbiter_pkg.sv
// Shared spio definitions: link packet width, arbiter state encoding and
// round-robin index helpers used by spio_pkt_arbiter and spio_rr_select.
`ifndef PKT_BITS
`define PKT_BITS 72
`endif

package spio_pkt_arbiter_pkg;

  localparam int RR_IDX_W     = 2;
  localparam int RR_MAX_PORTS = 1 << RR_IDX_W;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

  // (ptr + off) mod n, valid for ptr < n and 1 <= off <= n
  function automatic logic [RR_IDX_W-1:0] rr_wrap(input logic [RR_IDX_W-1:0] ptr,
                                                  input int off, input int n);
    int s;
    s = int'(ptr) + off;
    if (s >= n) s = s - n;
    return s[RR_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/spio_rr_select.sv
// Combinational round-robin pick: first requester after ptr, with wrap-around.
module spio_rr_select
  import spio_pkt_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [RR_IDX_W-1:0]  ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [RR_IDX_W-1:0]  idx,
  output logic                 any
);

  logic [RR_MAX_PORTS-1:0] req_pad;
  logic [RR_IDX_W-1:0]     cand;

  // Scan from farthest to nearest so the nearest requester wins last.
  always_comb begin
    req_pad                = '0;
    req_pad[NUM_PORTS-1:0] = req;
    idx                    = '0;
    any                    = 1'b0;
    cand                   = '0;
    for (int off = NUM_PORTS; off >= 1; off--) begin
      cand = rr_wrap(ptr, off, NUM_PORTS);
      if (req_pad[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      gnt[i] = any && (idx == RR_IDX_W'(i));
    end
  end

endmodule

// File: rtl/spio_pkt_arbiter.sv
// Round-robin merge of NUM_PORTS SpiNNaker packet sources into one link register.
// Optional per-port saturating packet counters when SPIO_ARB_PKT_CNT_EN is defined.
module spio_pkt_arbiter
  import spio_pkt_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int CNT_BITS  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           port_en,
  input  logic [NUM_PORTS*`PKT_BITS-1:0] ipkt_data,
  input  logic [NUM_PORTS-1:0]           ipkt_vld,
  output logic [NUM_PORTS-1:0]           ipkt_rdy,
  output logic [`PKT_BITS-1:0]           opkt_data,
  output logic                           opkt_vld,
  input  logic                           opkt_rdy,
  output logic [1:0]                     opkt_src
`ifdef SPIO_ARB_PKT_CNT_EN
  ,
  output logic [NUM_PORTS*CNT_BITS-1:0]  pkt_cnt
`endif
);

  if (NUM_PORTS < 2 || NUM_PORTS > RR_MAX_PORTS || CNT_BITS < 1) begin : g_bad_param
    $error("spio_pkt_arbiter: NUM_PORTS must be 2..4 and CNT_BITS >= 1");
  end

  arb_state_t          state, state_nxt;
  logic [RR_IDX_W-1:0] last_grant;
  logic [NUM_PORTS-1:0] req, gnt;
  logic [RR_IDX_W-1:0] win_idx;
  logic                win_any;
  logic                load;
  logic                take;

  assign req      = ipkt_vld & port_en;
  assign opkt_vld = (state == ST_FULL);
  assign load     = !opkt_vld || opkt_rdy;
  assign take     = load && win_any && !rst;
  assign ipkt_rdy = (load && !rst) ? gnt : '0;

  spio_rr_select #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr_select (
    .req(req),
    .ptr(last_grant),
    .gnt(gnt),
    .idx(win_idx),
    .any(win_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load) state_nxt = win_any ? ST_FULL : ST_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= RR_IDX_W'(NUM_PORTS - 1);
      opkt_src   <= '0;
    end else if (take) begin
      last_grant <= win_idx;
      opkt_src   <= win_idx;
    end
  end

  // Output register: data path carries no reset, only the control above.
  always_ff @(posedge clk) begin
    if (take) opkt_data <= ipkt_data[int'(win_idx)*`PKT_BITS +: `PKT_BITS];
  end

`ifdef SPIO_ARB_PKT_CNT_EN
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    logic [CNT_BITS-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                          cnt <= '0;
      else if (ipkt_vld[i] && ipkt_rdy[i]) cnt <= sat_inc(cnt);
    end
    assign pkt_cnt[i*CNT_BITS +: CNT_BITS] = cnt;
  end
`endif

endmodule

// File: tb/tb_spio_pkt_arbiter.sv
// Randomized bench for spio_pkt_arbiter against a cycle-level behavioural model.
`ifndef PKT_BITS
`define PKT_BITS 72
`endif

module tb_spio_pkt_arbiter;

  localparam int NP = 2;
  localparam int PB = `PKT_BITS;
  localparam int CB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     port_en;
  logic [NP*PB-1:0]  ipkt_data;
  logic [NP-1:0]     ipkt_vld;
  logic [NP-1:0]     ipkt_rdy;
  logic [PB-1:0]     opkt_data;
  logic              opkt_vld;
  logic              opkt_rdy;
  logic [1:0]        opkt_src;
`ifdef SPIO_ARB_PKT_CNT_EN
  logic [NP*CB-1:0]  pkt_cnt;
`endif

  spio_pkt_arbiter #(
    .NUM_PORTS(NP),
    .CNT_BITS(CB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .port_en(port_en),
    .ipkt_data(ipkt_data),
    .ipkt_vld(ipkt_vld),
    .ipkt_rdy(ipkt_rdy),
    .opkt_data(opkt_data),
    .opkt_vld(opkt_vld),
    .opkt_rdy(opkt_rdy),
    .opkt_src(opkt_src)
`ifdef SPIO_ARB_PKT_CNT_EN
    ,
    .pkt_cnt(pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: contents of the output register and round-robin memory
  logic          m_vld;
  int            m_src;
  logic [PB-1:0] m_data;
  int            m_last;
  int            m_cnt[NP];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_src  = 0;
    m_last = NP - 1;
    for (int i = 0; i < NP; i++) m_cnt[i] = 0;
  endtask

  function automatic logic [NP*PB-1:0] rnd_dat();
    logic [NP*PB-1:0] d;
    d = '0;
    for (int i = 0; i < NP*PB; i += 32) d = (d << 32) | (NP*PB)'($urandom);
    return d;
  endfunction

  // One clock cycle: drive at negedge, check combinational and registered outputs,
  // then advance the model at the rising edge.
  task automatic step(input logic [NP-1:0] en, input logic [NP-1:0] vld,
                      input logic rdy, input logic [NP*PB-1:0] dat);
    logic          load;
    int            win;
    logic [NP-1:0] exp_rdy;
    @(negedge clk);
    port_en   = en;
    ipkt_vld  = vld;
    opkt_rdy  = rdy;
    ipkt_data = dat;
    #1;
    load = !m_vld || rdy;
    win  = -1;
    if (load) begin
      for (int off = 1; off <= NP; off++) begin
        int p;
        p = (m_last + off) % NP;
        if (win < 0 && (((en & vld) >> p) & NP'(1)) != '0) win = p;
      end
    end
    exp_rdy = (win >= 0) ? (NP'(1) << win) : '0;
    chk("ipkt_rdy", ipkt_rdy, exp_rdy);
    chk("opkt_vld", opkt_vld, m_vld);
    if (m_vld) begin
      chk("opkt_src", opkt_src, m_src);
      chk("opkt_data", opkt_data, m_data);
    end
`ifdef SPIO_ARB_PKT_CNT_EN
    for (int i = 0; i < NP; i++) chk("pkt_cnt", pkt_cnt[i*CB +: CB], m_cnt[i]);
`endif
    @(posedge clk);
    if (load) begin
      if (win >= 0) begin
        m_vld  = 1'b1;
        m_src  = win;
        m_data = dat[win*PB +: PB];
        m_last = win;
        if (m_cnt[win] < (1 << CB) - 1) m_cnt[win]++;
      end else begin
        m_vld = 1'b0;
      end
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_vld", opkt_vld, 0);
    chk("rst_src", opkt_src, 0);
    chk("rst_rdy", ipkt_rdy, 0);
`ifdef SPIO_ARB_PKT_CNT_EN
    chk("rst_cnt", pkt_cnt, 0);
`endif
    model_reset();
    @(negedge clk);
    ipkt_vld = '0;
    rst      = 1'b0;
  endtask

  initial begin
    logic [PB-1:0]    pkt;
    logic [NP*PB-1:0] dat;
    rst       = 1'b1;
    port_en   = '1;
    ipkt_vld  = '0;
    ipkt_data = '0;
    opkt_rdy  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vld", opkt_vld, 0);
    chk("reset_src", opkt_src, 0);
    chk("reset_rdy", ipkt_rdy, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Both ports streaming: alternating grants, one packet per cycle
    for (int k = 0; k < 6; k++) begin
      step(2'b11, 2'b11, 1'b1, rnd_dat());
      #1;
      chk("rr_src", opkt_src, k % 2);
      chk("rr_vld", opkt_vld, 1);
    end

    // Downstream stalled: register holds, nothing accepted
    for (int k = 0; k < 5; k++) begin
      step(2'b11, 2'b11, 1'b0, rnd_dat());
      #1;
      chk("hold_rdy", ipkt_rdy, 0);
    end

    // Port 0 disabled: only port 1 may win
    for (int k = 0; k < 4; k++) begin
      step(2'b10, 2'b11, 1'b1, rnd_dat());
      #1;
      chk("en_src", opkt_src, 1);
      chk("en_rdy0", ipkt_rdy & 2'b01, 0);
    end

    // Single known packet on port 1 passes through bit-exact
    step(2'b11, 2'b00, 1'b1, rnd_dat());
    pkt = 72'h0_00000000_12345678_5;
    dat = rnd_dat();
    dat[PB +: PB] = pkt;
    step(2'b11, 2'b10, 1'b1, dat);
    #1;
    chk("pkt_data", opkt_data, pkt);
    chk("pkt_src", opkt_src, 1);
    chk("pkt_vld", opkt_vld, 1);
    step(2'b11, 2'b00, 1'b0, rnd_dat());

    // Reset while full and stalled discards the packet; port 0 wins first
    step(2'b11, 2'b11, 1'b0, rnd_dat());
    pulse_rst();
    step(2'b11, 2'b11, 1'b1, rnd_dat());
    #1;
    chk("post_rst_src", opkt_src, 0);
    chk("post_rst_vld", opkt_vld, 1);

`ifdef SPIO_ARB_PKT_CNT_EN
    pulse_rst();
    for (int k = 0; k < 20; k++) step(2'b01, 2'b01, 1'b1, rnd_dat());
    #1;
    chk("cnt0_sat", pkt_cnt[CB-1:0], 4'hF);
    chk("cnt1_zero", pkt_cnt[2*CB-1:CB], 0);
    step(2'b11, 2'b00, 1'b1, rnd_dat());
`endif

    // Random traffic, enables, back-pressure and occasional resets
    for (int k = 0; k < 600; k++) begin
      logic [NP-1:0] en;
      en = ($urandom_range(0, 7) == 0) ? NP'($urandom) : '1;
      if ($urandom_range(0, 99) == 0) pulse_rst();
      step(en, NP'($urandom), ($urandom_range(0, 3) != 0), rnd_dat());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spio_pkt_arbiter.md
SPIO_PKT_ARBITER -- requirements
Module: spio_pkt_arbiter

Interface
REQ-001 SHALL take parameter: NUM_PORTS, 2, number of packet sources sharing one SpiNNaker packet link (legal 2..4).
REQ-002 SHALL take parameter: CNT_BITS, 16, width of each per-port packet counter.
REQ-003 SHALL have port: clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: port_en  input  NUM_PORTS  per-port enable; bit i=0 excludes port i from arbitration.
REQ-006 SHALL have port: ipkt_data  input  NUM_PORTS*`PKT_BITS  concatenated input packets; port i occupies bits [(i+1)*`PKT_BITS-1 : i*`PKT_BITS].
REQ-007 SHALL have port: ipkt_vld  input  NUM_PORTS  per-port packet valid.
REQ-008 SHALL have port: ipkt_rdy  output  NUM_PORTS  per-port packet accept.
REQ-009 SHALL have port: opkt_data  output  `PKT_BITS  merged packet to SpiNNaker link transmitter.
REQ-010 SHALL have port: opkt_vld  output  1  merged packet valid.
REQ-011 SHALL have port: opkt_rdy  input  1  downstream ready.
REQ-012 SHALL have port: opkt_src  output  2  index of the port that supplied the packet currently in opkt_data.
REQ-013 SHALL have port (only with SPIO_ARB_PKT_CNT_EN): pkt_cnt  output  NUM_PORTS*CNT_BITS  per-port accepted-packet counters, same packing as ipkt_data.

Function
REQ-014 SHALL use valid/ready handshake on all packet interfaces; transfer occurs on a rising edge where vld && rdy.
REQ-015 SHALL hold a single-entry output register with two states: EMPTY (opkt_vld=0) and FULL (opkt_vld=1).
REQ-016 SHALL define load = !opkt_vld || opkt_rdy; arbitration happens only when load=1.
REQ-017 SHALL pick the winner round-robin among ports with ipkt_vld[i] && port_en[i], searching from (last_grant+1) mod NUM_PORTS upward with wrap-around.
REQ-018 SHALL drive ipkt_rdy combinationally: bit of winner = load, all other bits 0; at most one bit high in any cycle.
REQ-019 SHALL, on a winning transfer, register winner packet into opkt_data, winner index into opkt_src, set opkt_vld=1, update last_grant to winner (EMPTY/FULL->FULL).
REQ-020 SHALL, when load=1 and no eligible requester, clear opkt_vld (FULL->EMPTY on opkt_rdy, EMPTY stays EMPTY); last_grant unchanged.
REQ-021 SHALL keep opkt_data and opkt_src stable while opkt_vld && !opkt_rdy.
REQ-022 SHALL give latency of one cycle input-acceptance to opkt_vld and sustain one packet per cycle when opkt_rdy is held high.
REQ-023 SHALL pass packet contents unmodified (key, payload and parity bits untouched).
REQ-024 SHALL ignore ipkt_vld of disabled ports; clearing port_en mid-operation SHALL NOT affect a packet already in the output register.
REQ-025 SHALL guarantee any enabled continuously-valid port is granted within NUM_PORTS consecutive transfers.

Reset
REQ-026 SHALL on rst: opkt_vld=0, opkt_src=0, last_grant=NUM_PORTS-1 (port 0 first priority), counters=0; opkt_data undefined (no reset required).
REQ-027 SHALL discard any packet in the output register when rst asserts mid-operation; ipkt_rdy SHALL be 0 while rst high.

Configuration
REQ-028 SHALL compile per-port packet counters and pkt_cnt port only when SPIO_ARB_PKT_CNT_EN is defined.
REQ-029 SHALL, with SPIO_ARB_PKT_CNT_EN, increment counter i on each accepted transfer from port i, saturating at all-ones.
REQ-030 SHALL, without SPIO_ARB_PKT_CNT_EN, contain no counter logic; arbitration behaviour identical.

Structure
REQ-031 SHALL take `PKT_BITS from the shared SpiNNaker link header; arbiter state encodings and round-robin width constant SHALL live in the shared spio header.
REQ-032 SHALL implement winner selection as sub-module spio_rr_select (combinational request mask + pointer -> one-hot grant and index).

Verification
REQ-033 SHALL cover: reset, ports 0 and 1 valid continuously, opkt_rdy=1 -> opkt_src sequence 0,1,0,1, one packet per cycle.
REQ-034 SHALL cover: FULL with opkt_rdy=0 for 5 cycles -> opkt_data/opkt_src constant, all ipkt_rdy=0.
REQ-035 SHALL cover: port_en=2'b10, both valid -> only port 1 granted; ipkt_rdy[0] never 1.
REQ-036 SHALL cover: single packet 72'h0_00000000_12345678_5 on port 1 -> appears bit-exact on opkt_data one cycle later with opkt_src=1.
REQ-037 SHALL cover: rst pulsed while FULL and opkt_rdy=0 -> opkt_vld=0 immediately, first post-reset grant to port 0.
REQ-038 SHALL cover (SPIO_ARB_PKT_CNT_EN, CNT_BITS=4): 20 transfers from port 0 -> counter 0 saturates at 4'hF, counter 1 stays 0.
